// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(4x4,3x3) transform units.
// Holds the tile geometry, the A^T coefficients and the FSM state type.
package winograd_pkg;

  localparam int TILE_IN  = 6;
  localparam int TILE_OUT = 4;
  localparam int KERNEL   = 3;

  // The datapath realises these coefficients with shifts and adds; kept here for reference models.
  localparam int AT [TILE_OUT][TILE_IN] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COLS = 2'd1,
    ROWS = 2'd2,
    DONE = 2'd3
  } wino_state_e;

endpackage

// File: rtl/wino_at_vec.sv
// Combinational 6->4 product with A^T using shift/add only.
// Output is 5 bits wider than the input, which keeps the product exact.
module wino_at_vec #(
  parameter int IN_W = 32
) (
  input  logic signed [IN_W-1:0] x [6],
  output logic signed [IN_W+4:0] y [4]
);

  logic signed [IN_W+4:0] xe [6];
  logic signed [IN_W+4:0] s12, d12, s34, d34;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      xe[i] = {{5{x[i][IN_W-1]}}, x[i]};
    end
    s12 = xe[1] + xe[2];
    d12 = xe[1] - xe[2];
    s34 = xe[3] + xe[4];
    d34 = xe[3] - xe[4];
    y[0] = xe[0] + s12 + s34;
    y[1] = d12 + (d34 <<< 1);
    y[2] = s12 + (s34 <<< 2);
    y[3] = d12 + (d34 <<< 3) + xe[5];
  end

endmodule

// File: rtl/output_transform_unit.sv
// Winograd F(4x4,3x3) output transform Y = A^T * M * A, computed as a
// column pass (one column of T per cycle) followed by a row pass (one row of Y per cycle).
module output_transform_unit
  import winograd_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] matrix_in  [6][6],
  output logic signed [DATA_WIDTH-1:0] matrix_out [4][4],
  output logic                         transform_done,
  output logic                         busy
);

  localparam int TW = DATA_WIDTH + 5;
  localparam int RW = DATA_WIDTH + 10;

  wino_state_e                  state_q, state_d;
  logic [2:0]                   col_idx_q, col_idx_d;
  logic [1:0]                   row_idx_q, row_idx_d;
  logic signed [DATA_WIDTH-1:0] m_q [6][6];
  logic signed [DATA_WIDTH-1:0] m_d [6][6];
  logic signed [TW-1:0]         t_q [4][6];
  logic signed [TW-1:0]         t_d [4][6];
  logic signed [DATA_WIDTH-1:0] out_q [4][4];
  logic signed [DATA_WIDTH-1:0] out_d [4][4];
  logic                         done_q, done_d;
  logic                         busy_q, busy_d;

  logic signed [DATA_WIDTH-1:0] col_x [6];
  logic signed [TW-1:0]         col_y [4];
  logic signed [TW-1:0]         row_x [6];
  logic signed [RW-1:0]         row_y [4];
  logic                         row_y_unused;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      col_x[i] = m_q[i][col_idx_q];
      row_x[i] = t_q[row_idx_q][i];
    end
  end

  wino_at_vec #(.IN_W(DATA_WIDTH)) u_col_pass (.x(col_x), .y(col_y));
  wino_at_vec #(.IN_W(TW))         u_row_pass (.x(row_x), .y(row_y));

  // Results wrap to DATA_WIDTH; the guard bits of the row pass are intentionally dropped.
  assign row_y_unused = ^{row_y[0][RW-1:DATA_WIDTH], row_y[1][RW-1:DATA_WIDTH],
                          row_y[2][RW-1:DATA_WIDTH], row_y[3][RW-1:DATA_WIDTH]};

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    m_d       = m_q;
    t_d       = t_q;
    out_d     = out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d       = matrix_in;
          col_idx_d = 3'd0;
          state_d   = COLS;
        end
      end
      COLS: begin
        for (int i = 0; i < 4; i++) begin
          t_d[i][col_idx_q] = col_y[i];
        end
        if (col_idx_q == 3'd5) begin
          row_idx_d = 2'd0;
          state_d   = ROWS;
        end else begin
          col_idx_d = col_idx_q + 3'd1;
        end
      end
      ROWS: begin
        for (int j = 0; j < 4; j++) begin
          out_d[row_idx_q][j] = row_y[j][DATA_WIDTH-1:0];
        end
        if (row_idx_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          row_idx_d = row_idx_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      col_idx_q <= 3'd0;
      row_idx_q <= 2'd0;
      m_q       <= '{default: '0};
      t_q       <= '{default: '0};
      out_q     <= '{default: '0};
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      m_q       <= m_d;
      t_q       <= t_d;
      out_q     <= out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign matrix_out     = out_q;
  assign transform_done = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_output_transform_unit.sv
// Bench for output_transform_unit: stimulus pushes expected tiles and done cycles into a
// scoreboard queue; a monitor pops and compares on every transform_done pulse.
module tb_output_transform_unit;

  typedef struct packed {
    logic [31:0]       cyc;
    logic [15:0][31:0] y;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic signed [31:0] m_in  [6][6];
  logic signed [31:0] m_out [4][4];
  logic              transform_done;
  logic              busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tile_no = 0;
  int   cyc     = 0;
  exp_t sb [$];

  int at_c [4][6] = '{
    '{1, 1,  1, 1,  1, 0},
    '{0, 1, -1, 2, -2, 0},
    '{0, 1,  1, 4,  4, 0},
    '{0, 1, -1, 8, -8, 1}
  };

  output_transform_unit #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .matrix_in      (m_in),
    .matrix_out     (m_out),
    .transform_done (transform_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer matrix products with multiplications, wrapped to 32 bits.
  function automatic logic [15:0][31:0] model_y();
    longint t [4][6];
    longint acc;
    logic [15:0][31:0] r;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 6; c++) begin
        t[i][c] = 0;
        for (int k = 0; k < 6; k++) t[i][c] += longint'(at_c[i][k]) * longint'(m_in[k][c]);
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int c = 0; c < 6; c++) acc += t[i][c] * longint'(at_c[j][c]);
        r[i*4+j] = acc[31:0];
      end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && transform_done) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        tile_no++;
        check($sformatf("tile%0d done_cycle", tile_no), cyc, e.cyc);
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            check($sformatf("tile%0d Y[%0d][%0d]", tile_no, i, j), m_out[i][j], e.y[i*4+j]);
      end
    end
  end

  task automatic clear_m();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) m_in[i][j] = 0;
  endtask

  task automatic set_all_ones();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) m_in[i][j] = 1;
  endtask

  // Drives start for the E0 edge; returns the cycle count just after E0.
  task automatic issue(input logic keep_start, output int c0);
    logic [15:0][31:0] y;
    @(negedge clk);
    y = model_y();
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    sb.push_back({32'(c0 + 10), y});
    if (!keep_start) start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done_timeout: got queue %0d busy %0b required 0 0", sb.size(), busy);
    end
    @(negedge clk);
  endtask

  task automatic check_zero_out(input string name);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s Y[%0d][%0d]", name, i, j), m_out[i][j], 32'h0);
  endtask

  initial begin
    int c0;
    clear_m();
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, transform_done}, 32'h0);
    check_zero_out("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: unit impulse
    clear_m(); m_in[0][0] = 1;
    issue(1'b0, c0);
    check("t1 busy_after_start", {31'b0, busy}, 32'h1);
    wait_done();
    check("t1 Y00", m_out[0][0], 32'd1);
    check("t1 Y33", m_out[3][3], 32'd0);

    // 2: all ones
    set_all_ones();
    issue(1'b0, c0);
    wait_done();
    check("t2 Y00", m_out[0][0], 32'd25);
    check("t2 Y02", m_out[0][2], 32'd50);
    check("t2 Y22", m_out[2][2], 32'd100);
    check("t2 Y03", m_out[0][3], 32'd5);
    check("t2 Y33", m_out[3][3], 32'd1);
    check("t2 Y11", m_out[1][1], 32'd0);

    // 3: negative centre element
    clear_m(); m_in[3][3] = -1;
    issue(1'b0, c0);
    wait_done();
    check("t3 Y00", m_out[0][0], 32'hFFFF_FFFF);
    check("t3 Y12", m_out[1][2], 32'hFFFF_FFF8);
    check("t3 Y33", m_out[3][3], 32'hFFFF_FFC0);

    // 4: wraparound
    clear_m(); m_in[3][3] = 32'sd67108864;
    issue(1'b0, c0);
    wait_done();
    check("t4 Y33", m_out[3][3], 32'h0);
    check("t4 Y23", m_out[2][3], 32'h8000_0000);
    check("t4 Y00", m_out[0][0], 32'h0400_0000);

    // 5a: start while busy is ignored
    set_all_ones();
    issue(1'b0, c0);
    while (cyc != c0 + 2) @(negedge clk);
    clear_m(); m_in[0][0] = 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t5 busy_mid", {31'b0, busy}, 32'h1);
    wait_done();
    check("t5 Y00_first_snapshot", m_out[0][0], 32'd25);
    repeat (5) @(negedge clk);
    check("t5 busy_after", {31'b0, busy}, 32'h0);

    // 5b: reset mid-tile aborts with no done
    clear_m(); m_in[3][3] = -1;
    issue(1'b0, c0);
    while (cyc != c0 + 4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("t5 rst busy", {31'b0, busy}, 32'h0);
    check_zero_out("t5 rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("t5 post_rst busy", {31'b0, busy}, 32'h0);
    check_zero_out("t5 post_rst");

    // 6: back-to-back with start held high
    clear_m(); m_in[0][0] = 1;
    issue(1'b1, c0);
    clear_m(); m_in[3][3] = -1;
    while (cyc != c0 + 11) @(negedge clk);
    check("t6 idle_before_restart", {31'b0, busy}, 32'h0);
    begin
      logic [15:0][31:0] y;
      y = model_y();
      @(posedge clk);
      #1;
      sb.push_back({32'(cyc + 10), y});
      start = 1'b0;
      check("t6 restart_cycle", cyc, 32'(c0 + 12));
    end
    wait_done();
    check("t6 Y33", m_out[3][3], 32'hFFFF_FFC0);
    check("t6 queue_empty", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
